io_port_bank: RTL

//  Parametrised memory-mapped I/O bank for the risc_cpu top level: NPORTS input and NPORTS output ports of W bits.

---
 rtl/io_port_bank_pkg.sv | 31 +++
 rtl/io_port_bank_if.sv | 25 ++
 rtl/io_port_bank_sync_edge.sv | 48 ++++
 rtl/io_port_bank.sv | 130 +++++++++++++
 4 files changed

// File: rtl/io_port_bank_pkg.sv
// io_port_pkg: shared constants and address-map helpers for io_port_bank.
//   out_base()          first OUT_i address
//   in_base(nports)     first IN_i address
//   chg_base(nports)    first CHG_i address
//   ctrl_addr(nports)   CTRL register address
//   CTRL_IRQ_EN / CTRL_PAT_EN   CTRL bit positions
//   ARM_CYCLES          post-reset cycles before change detection is armed
package io_port_pkg;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_PAT_EN = 1;
    localparam int CTRL_W      = 2;
    localparam int ARM_CYCLES  = 3;

    function automatic int out_base();
        return 0;
    endfunction

    function automatic int in_base(input int nports);
        return nports;
    endfunction

    function automatic int chg_base(input int nports);
        return 2 * nports;
    endfunction

    function automatic int ctrl_addr(input int nports);
        return 3 * nports;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: single-cycle command bus between the core and io_port_bank.
//   wr_en, rd_en, addr, wdata   core -> bank command
//   rdata, rd_valid             bank -> core read return, one cycle after rd_en
// Modports: master (core side), slave (bank side).
interface io_port_bank_if #(
    parameter int W      = 8,
    parameter int ADDR_W = 6
) ();
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
    logic [W-1:0]      rdata;
    logic              rd_valid;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rd_valid
    );
endinterface

// File: rtl/io_port_bank_sync_edge.sv
// io_sync_edge: per-port input conditioning.
//   clk, rst     clock, synchronous active-high reset
//   armed        enables change detection (low during the post-reset window)
//   d_in         asynchronous W-bit input
//   sync_out     synchronised value (second sync stage)
//   chg          registered 1-cycle pulse: synchronised value differs from history
module io_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         armed,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] sync_out,
    output logic         chg
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] s3_q, s3_d;
    logic         chg_q, chg_d;

    always_comb begin
        s1_d  = d_in;
        s2_d  = s1_q;
        s3_d  = s2_q;
        // Registering the compare puts the flag set three edges after the input edge.
        chg_d = armed & (s2_q != s3_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            chg_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            chg_q <= chg_d;
        end
    end

    assign sync_out = s2_q;
    assign chg      = chg_q;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of NPORTS input and NPORTS output ports.
//   clk, rst     clock, synchronous active-high reset
//   bus          io_port_bank_if slave: write/read commands, registered read return
//   port_in      asynchronous inputs, port i = [i*W +: W]
//   port_out     output lanes (OUT regs, or pattern counter when pat_en)
//   out_strobe   bit i pulses for one cycle after OUT_i is written
//   irq          registered irq_en & any change flag
// Map: OUT_i at i, IN_i at NPORTS+i, CHG_i at 2*NPORTS+i, CTRL at 3*NPORTS.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int W      = 8,
    parameter int NPORTS = 16,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    io_port_bank_if.slave         bus,
    input  logic [NPORTS*W-1:0]   port_in,
    output logic [NPORTS*W-1:0]   port_out,
    output logic [NPORTS-1:0]     out_strobe,
    output logic                  irq
);

    logic [NPORTS-1:0][W-1:0] out_q, out_d;
    logic [NPORTS-1:0]        flag_q, flag_d;
    logic [NPORTS-1:0]        strobe_q, strobe_d;
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [W-1:0]             pat_q, pat_d;
    logic [W-1:0]             rdata_q, rdata_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     irq_q, irq_d;
    logic [1:0]               arm_cnt_q, arm_cnt_d;
    logic                     armed;

    logic [NPORTS-1:0][W-1:0] sync_val;
    logic [NPORTS-1:0]        chg;

    assign armed = (arm_cnt_q == 2'(ARM_CYCLES));

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        io_sync_edge #(
            .W (W)
        ) u_sync (
            .clk      (clk),
            .rst      (rst),
            .armed    (armed),
            .d_in     (port_in[i*W +: W]),
            .sync_out (sync_val[i]),
            .chg      (chg[i])
        );
    end

    always_comb begin
        out_d      = out_q;
        ctrl_d     = ctrl_q;
        strobe_d   = '0;
        flag_d     = flag_q;
        rdata_d    = '0;
        rd_valid_d = bus.rd_en;
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        pat_d      = ctrl_q[CTRL_PAT_EN] ? pat_q + W'(1) : pat_q;
        irq_d      = ctrl_q[CTRL_IRQ_EN] & (|flag_q);

        if (bus.wr_en) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (bus.addr == ADDR_W'(out_base() + i)) begin
                    out_d[i]    = bus.wdata;
                    strobe_d[i] = 1'b1;
                end
            end
            if (bus.addr == ADDR_W'(ctrl_addr(NPORTS))) begin
                ctrl_d = bus.wdata[CTRL_W-1:0];
            end
        end

        // Read data is taken from current (pre-write) register state.
        if (bus.rd_en) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (bus.addr == ADDR_W'(out_base() + i)) begin
                    rdata_d = out_q[i];
                end
                if (bus.addr == ADDR_W'(in_base(NPORTS) + i)) begin
                    rdata_d = sync_val[i];
                end
                if (bus.addr == ADDR_W'(chg_base(NPORTS) + i)) begin
                    rdata_d   = W'(flag_q[i]);
                    flag_d[i] = 1'b0;
                end
            end
            if (bus.addr == ADDR_W'(ctrl_addr(NPORTS))) begin
                rdata_d = W'(ctrl_q);
            end
        end

        // A change arriving in the read-clear cycle keeps the flag set.
        flag_d = flag_d | chg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            flag_q     <= '0;
            strobe_q   <= '0;
            ctrl_q     <= '0;
            pat_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            arm_cnt_q  <= '0;
        end else begin
            out_q      <= out_d;
            flag_q     <= flag_d;
            strobe_q   <= strobe_d;
            ctrl_q     <= ctrl_d;
            pat_q      <= pat_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign port_out     = ctrl_q[CTRL_PAT_EN] ? {NPORTS{pat_q}} : out_q;
    assign out_strobe   = strobe_q;
    assign irq          = irq_q;
    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
